// File: rtl/aes_sbox_fwd_seq.sv
// Sequential forward AES S-box (SubBytes) for a single byte.
//
// Computes out = Affine(in^-1) over GF(2^8) with the reduction polynomial 0x11B. The field
// inverse is formed as x^254 by square-and-multiply: seven iterations through one squarer
// and one general multiplier. The forward affine map is then applied in a separate cycle.
// Only one byte is in flight at a time.
//
// Ports:
//   clk_i        rising-edge clock
//   rst_i        synchronous reset, active-high
//   in_valid_i   in_data_i is presented
//   in_ready_o   block can accept a byte (high only while idle)
//   in_data_i    byte to substitute, sampled only at the accepting edge
//   out_valid_o  out_data_o holds a result
//   out_ready_i  downstream accepts out_data_o
//   out_data_o   substituted byte; keeps its last value after the handshake
//   busy_o       high while a byte is being processed or held for output
module aes_sbox_fwd_seq #(
    parameter logic [7:0] AFFINE_C = 8'h63
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       in_valid_i,
    output logic       in_ready_o,
    input  logic [7:0] in_data_i,
    output logic       out_valid_o,
    input  logic       out_ready_i,
    output logic [7:0] out_data_o,
    output logic       busy_o
);

    typedef enum logic [1:0] {
        StIdle,
        StCalc,
        StAffine,
        StDone
    } state_e;

    state_e     state_q, state_d;
    logic [7:0] sq_q, sq_d;
    logic [7:0] acc_q, acc_d;
    logic [2:0] cnt_q, cnt_d;
    logic       out_valid_q, out_valid_d;
    logic [7:0] out_data_q, out_data_d;

    logic [7:0] sq_sqr;
    logic [7:0] acc_mul;
    logic [7:0] affine;

    // GF(2^8) multiply, shift-and-add with reduction by x^8 + x^4 + x^3 + x + 1.
    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] t;
        p = 8'h00;
        t = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) begin
                p = p ^ t;
            end
            t = {t[6:0], 1'b0} ^ (t[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    // The new square feeds the accumulator in the same cycle, so after seven iterations
    // acc = x^(2+4+...+128) = x^254. An input of zero falls out as zero on its own.
    always_comb begin
        sq_sqr  = gf_mul(sq_q, sq_q);
        acc_mul = gf_mul(acc_q, sq_sqr);
    end

    // b[i] = a[i] ^ a[i-1] ^ a[i-2] ^ a[i-3] ^ a[i-4] (indices mod 8), i.e. XOR of
    // left-rotations by 0..4, followed by the constant.
    always_comb begin
        affine = acc_q
               ^ {acc_q[6:0], acc_q[7]}
               ^ {acc_q[5:0], acc_q[7:6]}
               ^ {acc_q[4:0], acc_q[7:5]}
               ^ {acc_q[3:0], acc_q[7:4]}
               ^ AFFINE_C;
    end

    always_comb begin
        state_d     = state_q;
        sq_d        = sq_q;
        acc_d       = acc_q;
        cnt_d       = cnt_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;

        unique case (state_q)
            StIdle: begin
                if (in_valid_i) begin
                    sq_d    = in_data_i;
                    acc_d   = 8'h01;
                    cnt_d   = 3'd0;
                    state_d = StCalc;
                end
            end
            StCalc: begin
                sq_d  = sq_sqr;
                acc_d = acc_mul;
                cnt_d = cnt_q + 3'd1;
                if (cnt_q == 3'd6) begin
                    state_d = StAffine;
                end
            end
            StAffine: begin
                out_data_d  = affine;
                out_valid_d = 1'b1;
                state_d     = StDone;
            end
            StDone: begin
                if (out_ready_i) begin
                    out_valid_d = 1'b0;
                    state_d     = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= StIdle;
            sq_q        <= 8'h00;
            acc_q       <= 8'h00;
            cnt_q       <= 3'd0;
            out_valid_q <= 1'b0;
            out_data_q  <= 8'h00;
        end else begin
            state_q     <= state_d;
            sq_q        <= sq_d;
            acc_q       <= acc_d;
            cnt_q       <= cnt_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
        end
    end

    assign in_ready_o  = (state_q == StIdle);
    assign busy_o      = (state_q != StIdle);
    assign out_valid_o = out_valid_q;
    assign out_data_o  = out_data_q;

endmodule
